// File: rtl/iir_coeff_loader_pkg.sv
// Shared types for the IIR coefficient loader: FSM state encoding and defaults.
package iir_coeff_loader_pkg;

    localparam int COEFF_WIDTH_DEF = 16;
    localparam int N_DEF           = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_PENDING = 2'd3
    } state_e;

endpackage

// File: rtl/iir_coeff_loader_bank.sv
// Shadow coefficient bank with indexed write, plus the active bank that iir_fb reads.
module iir_coeff_loader_bank #(
    parameter int COEFF_WIDTH = 16,
    parameter int N           = 4,
    parameter int IDX_W       = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en_i,
    input  logic [IDX_W-1:0]         wr_idx_i,
    input  logic [COEFF_WIDTH-1:0]   wr_data_i,
    input  logic                     commit_i,
    output logic [COEFF_WIDTH*N-1:0] active_o
);

    logic [COEFF_WIDTH*N-1:0] shadow_q;
    logic [COEFF_WIDTH*N-1:0] active_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            for (int t = 0; t < N; t++) begin
                if (wr_en_i && (wr_idx_i == IDX_W'(t))) begin
                    shadow_q[COEFF_WIDTH*t +: COEFF_WIDTH] <= wr_data_i;
                end
            end
            // Whole-bank copy so the filter never sees a partially updated set.
            if (commit_i) begin
                active_q <= shadow_q;
            end
        end
    end

    assign active_o = active_q;

endmodule

// File: rtl/iir_coeff_loader.sv
// Serial b-coefficient loader for iir_fb: frames words into a shadow bank, commits on sample_stb.
module iir_coeff_loader
    import iir_coeff_loader_pkg::*;
#(
    parameter int COEFF_WIDTH = COEFF_WIDTH_DEF,
    parameter int N           = N_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [COEFF_WIDTH-1:0]   wr_data,
    input  logic                     wr_last,
    input  logic                     cfg_abort,
    input  logic                     sample_stb,
    input  logic                     err_clr,
    output logic [COEFF_WIDTH*N-1:0] packed_coeffs,
    output logic                     commit_done,
    output logic                     err_len,
    output logic                     busy
);

    localparam int IDX_W = $clog2(N);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;
    logic             done_q;

    logic             accept;
    logic             last_slot;
    logic             err_set;
    logic             bank_wr_en;
    logic [IDX_W-1:0] bank_wr_idx;
    logic             commit;

    assign accept    = wr_valid && wr_ready && !cfg_abort;
    assign last_slot = (idx_q == IDX_W'(N - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            done_q  <= commit;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_set = 1'b0;
        if (cfg_abort) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (wr_last) begin
                            err_set = 1'b1;
                            idx_d   = '0;
                        end else begin
                            state_d = ST_LOAD;
                            idx_d   = IDX_W'(1);
                        end
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        if (!last_slot) begin
                            if (wr_last) begin
                                err_set = 1'b1;
                                state_d = ST_IDLE;
                                idx_d   = '0;
                            end else begin
                                idx_d = idx_q + IDX_W'(1);
                            end
                        end else begin
                            idx_d = '0;
                            if (wr_last) begin
                                state_d = ST_PENDING;
                            end else begin
                                err_set = 1'b1;
                                state_d = ST_DRAIN;
                            end
                        end
                    end
                end
                ST_DRAIN: begin
                    if (accept && wr_last) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PENDING: begin
                    if (sample_stb) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
        // A new error wins over a clear arriving in the same cycle.
        err_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_comb begin
        wr_ready    = (state_q != ST_PENDING);
        busy        = (state_q != ST_IDLE);
        bank_wr_en  = accept && ((state_q == ST_IDLE) || (state_q == ST_LOAD));
        bank_wr_idx = (state_q == ST_IDLE) ? '0 : idx_q;
        commit      = (state_q == ST_PENDING) && sample_stb && !cfg_abort;
    end

    iir_coeff_loader_bank #(
        .COEFF_WIDTH (COEFF_WIDTH),
        .N           (N),
        .IDX_W       (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (bank_wr_en),
        .wr_idx_i  (bank_wr_idx),
        .wr_data_i (wr_data),
        .commit_i  (commit),
        .active_o  (packed_coeffs)
    );

    assign commit_done = done_q;
    assign err_len     = err_q;

endmodule
